// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Literals carry an ST_ prefix so they never collide with the GUARD parameter.
    typedef enum logic [1:0] {
        ST_OFF,
        ST_GUARD,
        ST_SHOW
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: combinational hex digit to active-low seven-segment decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Full 0-F table; every code has a glyph.
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of NDIG hex digits onto one
// active-low segment bus, with a blank guard before each digit and
// frame-aligned commit of new values.
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN (leading-zero blanking).
//
// state    | meaning
// ---------+----------------------------------------------
// ST_OFF   | scan stopped, bus blank, waiting for en
// ST_GUARD | blank interval before the current digit
// ST_SHOW  | current digit enabled and driven for PRESC cycles
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int PRESC = 1000,
    parameter int GUARD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] din,
    output logic [6:0]        dout,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int CMAX = (PRESC > GUARD) ? PRESC : GUARD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NDIG);

    localparam logic [CW-1:0] P_LD      = CW'(PRESC - 1);
    localparam logic [CW-1:0] G_LD      = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [IW-1:0] LAST      = IW'(NDIG - 1);
    localparam bit            HAS_GUARD = (GUARD > 0);

    scan_state_t       state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [4*NDIG-1:0] pend, disp;
    logic [4*NDIG-1:0] commit_val;
    logic              commit, eof;
    scan_state_t       start_state;
    logic [CW-1:0]     start_cnt;
    logic [3:0]        sel_hex;
    logic [6:0]        seg_raw;
    logic              blank_digit;
    logic [6:0]        dout_n;
    logic [NDIG-1:0]   an_n;

    // A load coinciding with a commit is forwarded so the new value is not lost.
    assign commit_val  = load ? din : pend;
    assign start_state = HAS_GUARD ? ST_GUARD : ST_SHOW;
    assign start_cnt   = HAS_GUARD ? G_LD : P_LD;
    assign sel_hex     = disp[4*int'(idx) +: 4];

    hex7seg u_hex7seg (
        .hex (sel_hex),
        .seg (seg_raw)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [IW-1:0] lz_top, lz_top_n;

    // Highest nonzero digit of the value being committed; digit 0 is the floor.
    always_comb begin
        lz_top_n = '0;
        for (int i = 1; i < NDIG; i++) begin
            if (commit_val[4*i +: 4] != 4'h0) lz_top_n = IW'(i);
        end
    end

    // Leading-zero limit follows disp, updated only at commits.
    always_ff @(posedge clk) begin
        if (!rst) lz_top <= '0;
        else if (commit) lz_top <= lz_top_n;
    end

    assign blank_digit = (idx > lz_top);
`else
    assign blank_digit = 1'b0;
`endif

    // Next-state logic: slot down-counter terminates at zero; en low always wins.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        commit  = 1'b0;
        eof     = 1'b0;
        if (!en) begin
            state_n = ST_OFF;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    commit  = 1'b1;
                    idx_n   = '0;
                    state_n = start_state;
                    cnt_n   = start_cnt;
                end
                ST_GUARD: begin
                    if (cnt == '0) begin
                        state_n = ST_SHOW;
                        cnt_n   = P_LD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == '0) begin
                        state_n = start_state;
                        cnt_n   = start_cnt;
                        if (idx == LAST) begin
                            idx_n  = '0;
                            eof    = 1'b1;
                            commit = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Pin values for this cycle; gated by en so a stop blanks on the next edge.
    always_comb begin
        dout_n = SEG_BLANK;
        an_n   = '1;
        if (en && (state == ST_SHOW)) begin
            an_n[idx] = 1'b0;
            dout_n    = blank_digit ? SEG_BLANK : seg_raw;
        end
    end

    // State, data registers and registered pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_OFF;
            idx        <= '0;
            cnt        <= '0;
            pend       <= '0;
            disp       <= '0;
            dout       <= SEG_BLANK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            if (load)   pend <= din;
            if (commit) disp <= commit_val;
            dout       <= dout_n;
            an         <= an_n;
            frame_done <= eof;
        end
    end

endmodule
